// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, master FSM states and phase register layout
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;
  typedef enum logic {NORMAL, ERR2} mstate_t;
  typedef struct packed {
    logic valid;
    logic write;
    logic [3:0] addr;
    logic size;
    logic [15:0] wdata;
  } phase_t;
endpackage

// File: rtl/ahb_byte_lane.sv
// ahb_byte_lane: write-lane replication and read-lane extraction for 16-bit AHB data
module ahb_byte_lane (
  input  logic        i_size,
  input  logic        i_addr0,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_hrdata,
  output logic [15:0] o_hwdata,
  output logic [15:0] o_rdata
);
  assign o_hwdata = i_size ? i_wdata : {2{i_wdata[7:0]}};
  assign o_rdata = i_size ? i_hrdata : {8'h00, i_addr0 ? i_hrdata[15:8] : i_hrdata[7:0]};
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: valid/ready command stream to pipelined AHB-Lite transfers with wait-state and error handling
module ahb_lite_master
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic        cmd_size,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  haddr,
  output logic        hsize,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic        hsel,
  output logic [15:0] hwdata,
  input  logic [15:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);
  mstate_t r_state, w_next;
  phase_t r_aph, r_dph;
  logic w_accept, w_advance, w_done, w_err, w_unused;
  logic [15:0] w_rdata;
  assign htrans = (r_aph.valid && r_state == NORMAL) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsel = htrans[1];
  assign haddr = {r_aph.addr[3:1], r_aph.addr[0] & ~r_aph.size};
  assign hsize = r_aph.size;
  assign hwrite = r_aph.write;
  assign cmd_ready = !r_aph.valid || (hready && r_state == NORMAL);
  assign w_accept = cmd_valid && cmd_ready;
  assign w_advance = hready && hsel;
  assign w_done = hready && r_dph.valid;
  assign w_err = hresp || r_state == ERR2;
  assign w_unused = ^r_dph.addr[3:1];
  ahb_byte_lane u_lane (
    .i_size  (r_dph.size),
    .i_addr0 (r_dph.addr[0]),
    .i_wdata (r_dph.wdata),
    .i_hrdata(hrdata),
    .o_hwdata(hwdata),
    .o_rdata (w_rdata)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == NORMAL) w_next = (r_dph.valid && hresp && !hready) ? ERR2 : NORMAL;
    else w_next = hready ? NORMAL : ERR2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= NORMAL;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aph <= '0;
      r_dph <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (w_accept) r_aph <= '{1'b1, cmd_write, cmd_addr, cmd_size, cmd_wdata};
      else if (w_advance) r_aph.valid <= 1'b0;
      if (hready) r_dph <= w_advance ? r_aph : '0;
      rsp_valid <= w_done;
      rsp_err <= w_done && w_err;
      rsp_rdata <= (w_done && !r_dph.write) ? w_rdata : '0;
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: randomized AHB-Lite slave plus in-order memory scoreboard for ahb_lite_master
module tb_ahb_lite_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_size = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic rsp_valid, rsp_err, hsize, hwrite, hsel;
  logic [15:0] rsp_rdata, hwdata;
  logic [3:0] haddr;
  logic [1:0] htrans;
  logic [15:0] hrdata = '0;
  logic hready = 1'b1, hresp = 1'b0;

  ahb_lite_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .htrans(htrans), .hsel(hsel),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  typedef struct {logic w; logic [3:0] a; logic s; logic [15:0] d; int acc;} cmd_t;
  cmd_t cmd_q[$], iss_q[$], dir_q[$];
  int done_q[$];
  bit err_q[$];
  logic [7:0] ref_m[16];
  logic [15:0] slv_m[8];
  int n_err = 0, n_chk = 0, cyc = 0;
  bit cmd_pend = 0, rnd_on = 0, err_en = 0, wait_en = 0, lat_chk = 0;
  cmd_t cur;
  bit dp_act = 0, dp_w, dp_s, dp_eph;
  logic [3:0] dp_a;
  int dp_err, dp_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset();
    chk("rst_htrans", htrans, 0);
    chk("rst_hsel", hsel, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hsize", hsize, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
  endtask

  function automatic cmd_t mk(input logic w, input logic [3:0] a, input logic s, input logic [15:0] d);
    mk = '{w, a, s, d, 0};
  endfunction

  task automatic step();
    cmd_t c;
    bit e;
    logic [3:0] al;
    @(negedge clk);
    if (dp_act && dp_err == 1) begin hready = dp_eph; hresp = 1'b1; end
    else if (dp_act && dp_err == 2) begin hready = 1'b1; hresp = 1'b1; end
    else if (dp_act && dp_wait > 0) begin hready = 1'b0; hresp = 1'b0; end
    else begin hready = 1'b1; hresp = 1'b0; end
    hrdata = (dp_act && !dp_w && hready && !hresp) ? slv_m[dp_a[3:1]] : 16'($urandom);
    if (!cmd_pend) begin
      if (dir_q.size() > 0) begin cur = dir_q.pop_front(); cmd_pend = 1; end
      else if (rnd_on && $urandom_range(0, 3) != 0) begin
        cur = mk(1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom));
        cmd_pend = 1;
      end
      if (cmd_pend) begin cmd_write = cur.w; cmd_addr = cur.a; cmd_size = cur.s; cmd_wdata = cur.d; end
    end
    cmd_valid = cmd_pend;
    #1;
    if (rst) begin
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_idle", htrans, 0);
      return;
    end
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      e = err_q.pop_front();
      void'(done_q.pop_front());
      if (cmd_q.size() == 0) chk("rsp_order", 0, 1);
      else begin
        c = cmd_q.pop_front();
        if (lat_chk) chk("latency", cyc - c.acc, 2);
        chk("rsp_err", rsp_err, e);
        al = {c.a[3:1], 1'b0};
        if (!e && c.w) begin
          chk("rsp_wr_rdata", rsp_rdata, 0);
          if (c.s) begin ref_m[al] = c.d[7:0]; ref_m[al | 4'd1] = c.d[15:8]; end
          else ref_m[c.a] = c.d[7:0];
        end else if (!e)
          chk("rsp_rd_rdata", rsp_rdata, c.s ? {ref_m[al | 4'd1], ref_m[al]} : {8'h00, ref_m[c.a]});
      end
    end else if (rsp_valid) chk("rsp_spurious", 1, 0);
    cyc++;
    if (dp_act && dp_err == 1 && dp_eph) begin
      chk("err2_htrans", htrans, 0);
      chk("err2_hsel", hsel, 0);
    end
    if (dp_act) begin
      if (!hready) begin
        if (dp_err == 1) dp_eph = 1;
        else dp_wait--;
      end else begin
        if (dp_w && dp_err == 0) begin
          if (dp_s) slv_m[dp_a[3:1]] = hwdata;
          else begin
            chk("hwdata_rep", hwdata[15:8], hwdata[7:0]);
            if (dp_a[0]) slv_m[dp_a[3:1]][15:8] = hwdata[15:8];
            else slv_m[dp_a[3:1]][7:0] = hwdata[7:0];
          end
        end
        err_q.push_back(dp_err != 0);
        done_q.push_back(cyc);
        dp_act = 0;
      end
    end
    if (htrans == 2'b10 && hready) begin
      if (iss_q.size() == 0) chk("addr_spurious", 1, 0);
      else begin
        c = iss_q.pop_front();
        chk("haddr", haddr, c.s ? {c.a[3:1], 1'b0} : c.a);
        chk("hwrite", hwrite, c.w);
        chk("hsize", hsize, c.s);
        chk("hsel", hsel, 1);
      end
      dp_act = 1; dp_w = hwrite; dp_a = haddr; dp_s = hsize; dp_eph = 0;
      dp_err = (err_en && $urandom_range(0, 7) == 0) ? ($urandom_range(0, 3) == 0 ? 2 : 1) : 0;
      dp_wait = (wait_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    end
    if (cmd_valid && cmd_ready) begin
      cur.acc = cyc;
      cmd_q.push_back(cur);
      iss_q.push_back(cur);
      cmd_pend = 0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      slv_m[i] = 16'($urandom);
      ref_m[2*i] = slv_m[i][7:0];
      ref_m[2*i+1] = slv_m[i][15:8];
    end
    repeat (2) @(negedge clk);
    #1 chk_reset();
    @(negedge clk) rst = 1'b0;
    lat_chk = 1;
    dir_q.push_back(mk(1, 4'h4, 1, 16'hBEEF));
    dir_q.push_back(mk(1, 4'h6, 1, 16'h1234));
    dir_q.push_back(mk(0, 4'h6, 1, 16'h0000));
    dir_q.push_back(mk(1, 4'h2, 1, 16'hAB12));
    dir_q.push_back(mk(0, 4'h3, 0, 16'h0000));
    dir_q.push_back(mk(1, 4'h5, 0, 16'h0077));
    dir_q.push_back(mk(0, 4'h4, 1, 16'h0000));
    dir_q.push_back(mk(0, 4'h5, 0, 16'h0000));
    repeat (20) step();
    lat_chk = 0; rnd_on = 1; err_en = 1; wait_en = 1;
    repeat (1500) step();
    err_en = 0;
    for (int i = 0; i < 200 && !(dp_act && dp_w); i++) step();
    rnd_on = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset();
    cmd_valid = 1'b0; cmd_pend = 0; dp_act = 0;
    dir_q.delete();
    repeat (3) step();
    @(negedge clk) rst = 1'b0;
    cmd_q.delete(); iss_q.delete(); done_q.delete(); err_q.delete();
    for (int i = 0; i < 8; i++) begin
      ref_m[2*i] = slv_m[i][7:0];
      ref_m[2*i+1] = slv_m[i][15:8];
    end
    wait_en = 0; lat_chk = 1;
    dir_q.push_back(mk(1, 4'h8, 1, 16'hC0DE));
    dir_q.push_back(mk(0, 4'h9, 0, 16'h0000));
    dir_q.push_back(mk(0, 4'h8, 1, 16'h0000));
    repeat (12) step();
    rnd_on = 1;
    repeat (40) step();
    rnd_on = 0;
    for (int i = 0; i < 300 && (cmd_q.size() > 0 || cmd_pend); i++) step();
    chk("drain", cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
